// File: rtl/spi_if.sv
// SPI pin bundle between an external master and the spi_slave block.
// MISO is resolved to a tri-state pin here from the slave's data and enable.
interface spi_if;
  logic       SCK;
  logic       SS;
  logic       MOSI;
  logic       miso_q;
  logic       miso_en;
  logic       LED1;
  logic [7:0] rx_byte;
  wire        MISO;

  assign MISO = miso_en ? miso_q : 1'bz;

  modport slave  (input SCK, SS, MOSI, output miso_q, miso_en, LED1, rx_byte);
  modport master (output SCK, SS, MOSI, input MISO, miso_en, LED1, rx_byte);
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 byte slave oversampled by CLOCK_Y2: returns the in-frame byte index
// on MISO and shows bit 0 of the last completed received byte on LED1.
module spi_slave #(
  parameter int SYNC_STAGES = 3
) (
  input  logic CLOCK_Y2,
  input  logic RESET_N,
  spi_if.slave spi
);

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync, fill;
  logic                   sck_s, ss_s, mosi_s, fill_done;
  logic                   sck_d, ss_d;
  logic                   armed, in_frame;
  logic                   sck_rise, sck_fall, ss_fall, ss_rise, active;
  logic [2:0]             bit_cnt;
  logic [7:0]             byte_idx, tx_shift, rx_shift, rx_byte;
  logic                   miso_q, miso_en;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES-1];

  // A frame may only start after SS has been seen high on real pin samples,
  // so a reset released with SS already low never opens a frame.
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d & armed;
  assign ss_rise  = ss_s & ~ss_d;
  assign active   = in_frame & ~ss_s;

  always_ff @(posedge CLOCK_Y2 or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_sync  <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sck_d     <= 1'b1;
      ss_d      <= 1'b1;
      armed     <= 1'b0;
      in_frame  <= 1'b0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      miso_q    <= 1'b0;
      miso_en   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.SCK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
      if (fill_done && ss_s) armed <= 1'b1;

      if (ss_fall) begin
        in_frame <= 1'b1;
        bit_cnt  <= '0;
        byte_idx <= '0;
        tx_shift <= '0;
        miso_en  <= 1'b1;
      end else if (ss_rise) begin
        in_frame <= 1'b0;
        miso_en  <= 1'b0;
      end else if (active) begin
        if (sck_fall) begin
          miso_q   <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          if (bit_cnt == 3'd7) begin
            rx_byte  <= {rx_shift[6:0], mosi_s};
            byte_idx <= byte_idx + 8'd1;
            tx_shift <= byte_idx + 8'd1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      end
    end
  end

  assign spi.miso_q  = miso_q;
  assign spi.miso_en = miso_en;
  assign spi.rx_byte = rx_byte;
  assign spi.LED1    = rx_byte[0];

endmodule

// File: tb/tb_spi_slave.sv
// Directed/random bench for spi_slave acting as an SPI mode-3 master; expected
// values come from a frame-level model (byte k returns k mod 256, LED = last LSB).
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state
  int unsigned exp_idx;
  logic [7:0]  last_rx;

  spi_if bus ();

  spi_slave #(.SYNC_STAGES(3)) dut (
    .CLOCK_Y2 (clk),
    .RESET_N  (rst_n),
    .spi      (bus)
  );

  always #8 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Half an SCK period: 8 system clocks (SCK = CLOCK_Y2/16)
  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int b = 0; b < nbits; b++) begin
      bus.SCK  = 1'b0;
      bus.MOSI = tx[7-b];
      half();
      rx[7-b] = bus.MISO;
      bus.SCK = 1'b1;
      half();
    end
  endtask

  task automatic send_check(input logic [7:0] tx, input string tag);
    logic [7:0] rx;
    xfer(tx, 8, rx);
    check($sformatf("%s_miso", tag), {24'd0, rx}, exp_idx % 256);
    exp_idx++;
    last_rx = tx;
    check($sformatf("%s_led", tag), {31'd0, bus.LED1}, {31'd0, last_rx[0]});
    check($sformatf("%s_rxbyte", tag), {24'd0, bus.rx_byte}, {24'd0, last_rx});
  endtask

  task automatic frame_start();
    bus.SS = 1'b0;
    half();
    exp_idx = 0;
    check("miso_enabled", {31'd0, bus.miso_en}, 32'd1);
  endtask

  task automatic frame_end();
    bus.SS = 1'b1;
    half();
    check("miso_z", {31'd0, bus.miso_en}, 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] r;

    bus.SCK  = 1'b1;
    bus.SS   = 1'b1;
    bus.MOSI = 1'b0;
    exp_idx  = 0;
    last_rx  = 8'h00;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_miso_z", {31'd0, bus.miso_en}, 32'd0);
    check("rst_led", {31'd0, bus.LED1}, 32'd0);
    check("rst_rxbyte", {24'd0, bus.rx_byte}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // SCK activity with SS high is ignored
    xfer(8'hFF, 4, rx);
    check("idle_miso_z", {31'd0, bus.miso_en}, 32'd0);
    check("idle_led", {31'd0, bus.LED1}, 32'd0);
    check("idle_rxbyte", {24'd0, bus.rx_byte}, 32'd0);

    // Frame of 0x00..0x04, then 0xA5 and 0x5A
    frame_start();
    for (int i = 0; i < 5; i++) send_check(8'(i), $sformatf("seq%0d", i));
    send_check(8'hA5, "a5");
    send_check(8'h5A, "5a");

    // Abort after 4 bits: MISO z, LED and rx_byte untouched
    xfer(8'hFF, 4, rx);
    frame_end();
    check("abort_led", {31'd0, bus.LED1}, {31'd0, last_rx[0]});
    check("abort_rxbyte", {24'd0, bus.rx_byte}, {24'd0, last_rx});

    // New frame restarts index; then SS rise coincident with the 8th SCK rise
    frame_start();
    send_check(8'h3C, "restart");
    xfer(8'h81, 7, rx);
    bus.SCK  = 1'b0;
    bus.MOSI = 1'b1;
    half();
    bus.SCK = 1'b1;
    bus.SS  = 1'b1;
    half();
    check("simul_miso_z", {31'd0, bus.miso_en}, 32'd0);
    check("simul_led", {31'd0, bus.LED1}, {31'd0, last_rx[0]});
    check("simul_rxbyte", {24'd0, bus.rx_byte}, {24'd0, last_rx});

    // 257-byte random frame: index wraps back to 0x00 on byte 256
    frame_start();
    for (int i = 0; i < 257; i++) begin
      r = 8'($urandom);
      send_check(r, $sformatf("long%0d", i));
    end
    frame_end();

    // Reset mid-byte: immediate clear, then no activity until a fresh SS fall
    frame_start();
    xfer(8'hFF, 3, rx);
    rst_n = 1'b0;
    #1;
    check("midrst_miso_z", {31'd0, bus.miso_en}, 32'd0);
    check("midrst_led", {31'd0, bus.LED1}, 32'd0);
    check("midrst_rxbyte", {24'd0, bus.rx_byte}, 32'd0);
    last_rx = 8'h00;
    bus.SCK = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    xfer(8'hFF, 8, rx);
    half();
    check("post_rst_miso_z", {31'd0, bus.miso_en}, 32'd0);
    check("post_rst_led", {31'd0, bus.LED1}, 32'd0);
    check("post_rst_rxbyte", {24'd0, bus.rx_byte}, 32'd0);

    bus.SS = 1'b1;
    half();
    frame_start();
    send_check(8'($urandom), "after_rst0");
    send_check(8'($urandom), "after_rst1");
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
